// File: rtl/ps2_host_ctrl.sv
// PS/2 host sequencer: parity-checked receive FIFO plus host-to-device
// command transmit arbitrated on the shared open-drain clock/data lines.
module ps2_host_ctrl #(
  parameter int FREQ       = 25000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_code,
  input  logic       rx_parity,
  input  logic       rx_busy,
  input  logic       rx_rdy,
  input  logic       rx_error,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] key_code,
  output logic       key_valid,
  input  logic       key_pop,
  output logic       rx_perr,
  output logic       rx_ovf
);
  localparam int INHIBIT_CYC = FREQ * INHIBIT_US / 1000;
  localparam int TIMEOUT_CYC = FREQ * TIMEOUT_US / 1000;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  // state     | meaning
  // IDLE      | lines released, command and receive bytes accepted
  // WAIT_RX   | command latched, letting an in-flight receive frame finish
  // INHIBIT   | host holds clock low
  // REQ       | start bit on data, clock released, awaiting device clock
  // SHIFT     | data bits then parity, one per device falling edge
  // STOP      | data released for the stop bit
  // ACK       | sample device acknowledge on next falling edge
  // WAIT_IDLE | wait for both lines high before reporting success
  typedef enum logic [2:0] {
    IDLE, WAIT_RX, INHIBIT, REQ, SHIFT, STOP, ACK, WAIT_IDLE
  } state_t;

  state_t             state, state_n;
  logic               clk_s1, clk_s2, data_s1, data_s2;
  logic [3:0]         clk_hist;
  logic               fall;
  logic [7:0]         tx_byte, tx_byte_n;
  logic [3:0]         bit_idx, bit_idx_n;
  logic [INH_W-1:0]   inh_cnt, inh_cnt_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [1:0]         end_hist;
  logic               timed, tx_bit;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               rx_take, par_ok, push, pop, full, wr_en;

  // Framing errors never raise rx_rdy, so the error flag carries no state here.
  logic               rx_error_unused;
  assign rx_error_unused = rx_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_hist <= 4'hF;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
      clk_hist <= {clk_hist[2:0], clk_s2};
    end
  end

  assign fall   = (clk_hist == 4'b1100);
  assign timed  = (state == REQ) || (state == SHIFT) || (state == STOP) ||
                  (state == ACK) || (state == WAIT_IDLE);
  assign tx_bit = bit_idx[3] ? ~^tx_byte : tx_byte[bit_idx[2:0]];

  always_comb begin
    state_n     = state;
    tx_byte_n   = tx_byte;
    bit_idx_n   = bit_idx;
    inh_cnt_n   = inh_cnt;
    to_cnt_n    = timed ? to_cnt - TO_W'(1) : to_cnt;
    cmd_ready   = 1'b0;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        cmd_ready = 1'b1;
        tx_byte_n = cmd_data;
        state_n   = WAIT_RX;
      end
      WAIT_RX: if (!rx_busy) begin
        inh_cnt_n = INH_W'(INHIBIT_CYC - 1);
        state_n   = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == '0) begin
          to_cnt_n  = TO_W'(TIMEOUT_CYC - 1);
          bit_idx_n = 4'd0;
          state_n   = REQ;
        end else begin
          inh_cnt_n = inh_cnt - INH_W'(1);
        end
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        if (fall) state_n = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = ~tx_bit;
        if (fall) begin
          if (bit_idx == 4'd8) state_n = STOP;
          else bit_idx_n = bit_idx + 4'd1;
        end
      end
      STOP: if (fall) state_n = ACK;
      ACK: if (fall) begin
        if (data_s2) begin
          tx_err  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (clk_s2 && data_s2) begin
        tx_done = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Timeout overrides whatever the frame was doing this cycle.
    if (timed && to_cnt == '0) begin
      tx_done     = 1'b0;
      tx_err      = 1'b1;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      state_n     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_byte  <= 8'h00;
      bit_idx  <= 4'd0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      end_hist <= 2'b00;
    end else begin
      state    <= state_n;
      tx_byte  <= tx_byte_n;
      bit_idx  <= bit_idx_n;
      inh_cnt  <= inh_cnt_n;
      to_cnt   <= to_cnt_n;
      end_hist <= {end_hist[0], tx_done | tx_err};
    end
  end

  // Bytes seen just after a transmit are echoes of our own traffic.
  assign rx_take   = rx_rdy && (state == IDLE || state == WAIT_RX) && (end_hist == 2'b00);
  assign par_ok    = ^{rx_code, rx_parity};
  assign push      = rx_take && par_ok;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign key_valid = (count != '0);
  assign pop       = key_pop && key_valid;
  assign wr_en     = push && (!full || pop);
  assign rx_perr   = rx_take && !par_ok;
  assign rx_ovf    = push && full && !pop;
  assign key_code  = key_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: receive FIFO/parity path and command transmit
// against a cycle-stepped 10 kHz device model, with the core scaled to 1 MHz.
module tb_ps2_host_ctrl;
  localparam int FREQ    = 1000;
  localparam int INH_CYC = 100;    // 1000 kHz * 100 us
  localparam int TO_CYC  = 15000;  // 1000 kHz * 15000 us
  localparam int HALF    = 50;     // half period of a 10 kHz device clock

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [7:0] rx_code = 8'h00;
  logic       rx_parity = 1'b0, rx_busy = 1'b0, rx_rdy = 1'b0, rx_error = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, tx_done, tx_err;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_pop = 1'b0;
  logic       rx_perr, rx_ovf;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_ctrl #(.FREQ(FREQ), .INHIBIT_US(100), .TIMEOUT_US(15000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .rx_code(rx_code), .rx_parity(rx_parity), .rx_busy(rx_busy),
    .rx_rdy(rx_rdy), .rx_error(rx_error),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .key_code(key_code), .key_valid(key_valid), .key_pop(key_pop),
    .rx_perr(rx_perr), .rx_ovf(rx_ovf)
  );

  int n_done = 0, n_err = 0, n_ready = 0, n_inh = 0, n_both = 0;
  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_err) n_err++;
    if (cmd_ready) n_ready++;
    if (ps2_clk_oe) n_inh++;
    if (tx_done && tx_err) n_both++;
  end

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_oe_q[$];

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One receiver byte; good = parity acceptable, pop = dequeue in same cycle.
  task automatic rx_pulse(input logic [7:0] code, input logic par, input logic good,
                          input logic pop, input string tag);
    logic exp_ovf;
    logic [7:0] head;
    exp_ovf = good && (exp_q.size() == 4) && !pop;
    rx_code = code; rx_parity = par; rx_rdy = 1'b1; key_pop = pop;
    #1;
    if (pop) begin
      head = exp_q.pop_front();
      check8({tag, " head"}, key_code, head);
    end
    check1({tag, " perr"}, rx_perr, !good);
    check1({tag, " ovf"}, rx_ovf, exp_ovf);
    if (good && !exp_ovf) exp_q.push_back(code);
    step();
    rx_rdy = 1'b0; key_pop = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] head;
    head = 8'h00;
    key_pop = 1'b1;
    #1;
    check1({tag, " valid"}, key_valid, 1'b1);
    if (exp_q.size() > 0) head = exp_q.pop_front();
    check8({tag, " code"}, key_code, head);
    step();
    key_pop = 1'b0;
  endtask

  // pat[12] = start bit oe, pat[11:4] = oe after falls 1..8, then parity, stop, ack.
  task automatic start_tx(input logic [7:0] data, input logic [12:0] pat, input string tag);
    cmd_data = data; cmd_valid = 1'b1;
    #1;
    check1({tag, " cmd_ready"}, cmd_ready, 1'b1);
    for (int i = 12; i >= 0; i--) exp_oe_q.push_back(pat[i]);
    step();
    cmd_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1($sformatf("%s ready held %0d", tag, i), cmd_ready, 1'b0);
      step();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    #1;
    while (!ps2_clk_oe && n < 1000) begin @(posedge clk); #2; n++; end
    check1({tag, " inhibit seen"}, ps2_clk_oe, 1'b1);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin @(posedge clk); #2; n++; end
    check1({tag, " clk released"}, ps2_clk_oe, 1'b0);
    check1({tag, " start bit"}, ps2_data_oe, exp_oe_q.pop_front());
    step();
  endtask

  task automatic dev_clock(input int nfalls, input logic ack, input string tag);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 12) dev_data = ack;
      repeat (HALF) @(posedge clk);
      #1;
      dev_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
      if (exp_oe_q.size() > 0)
        check1($sformatf("%s oe after fall %0d", tag, k), ps2_data_oe, exp_oe_q.pop_front());
      dev_clk = 1'b1;
      if (k == 12) dev_data = 1'b1;
    end
  endtask

  initial begin
    int n;
    int d0, e0, r0, i0;
    logic [4:0] pars;

    repeat (3) @(posedge clk);
    #1;
    check1("rst clk_oe", ps2_clk_oe, 1'b0);
    check1("rst data_oe", ps2_data_oe, 1'b0);
    check1("rst key_valid", key_valid, 1'b0);
    check8("rst key_code", key_code, 8'h00);
    check1("rst tx_done", tx_done, 1'b0);
    check1("rst tx_err", tx_err, 1'b0);
    check1("rst cmd_ready", cmd_ready, 1'b0);
    reset = 1'b1;
    step();

    rx_pulse(8'h1C, 1'b0, 1'b1, 1'b0, "rx1c");
    #1;
    check1("rx1c latency", key_valid, 1'b1);
    check8("rx1c peek", key_code, exp_q[0]);
    pop_check("pop1c");
    #1;
    check1("empty after pop", key_valid, 1'b0);
    rx_pulse(8'h1C, 1'b1, 1'b0, 1'b0, "bad parity");
    #1;
    check1("bad parity dropped", key_valid, 1'b0);
    rx_error = 1'b1;
    step();
    rx_error = 1'b0;
    #1;
    check1("rx_error no push", key_valid, 1'b0);

    pars = 5'b10100;
    for (int i = 1; i <= 5; i++)
      rx_pulse(8'(i), pars[i-1], 1'b1, 1'b0, $sformatf("fill%0d", i));
    rx_pulse(8'h06, 1'b1, 1'b1, 1'b1, "full push+pop");
    rx_pulse(8'h07, 1'b0, 1'b1, 1'b0, "still full");
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
    #1;
    check1("drained", key_valid, 1'b0);
    key_pop = 1'b1;
    step();
    key_pop = 1'b0;
    #1;
    check1("pop empty ignored", key_valid, 1'b0);
    step();

    d0 = n_done; e0 = n_err; r0 = n_ready; i0 = n_inh;
    start_tx(8'hED, 13'b1_01001000_0_000, "ed");
    wait_req("ed");
    dev_clock(12, 1'b0, "ed");
    n = 0;
    while (n_done == d0 && n < 200) begin step(); n++; end
    repeat (5) step();
    checki("ed tx_done pulses", n_done - d0, 1);
    checki("ed tx_err pulses", n_err - e0, 0);
    checki("ed cmd_ready pulses", n_ready - r0, 1);
    checki("ed inhibit cycles", n_inh - i0, INH_CYC);
    check1("ed clk released", ps2_clk_oe, 1'b0);
    check1("ed data released", ps2_data_oe, 1'b0);

    d0 = n_done; e0 = n_err;
    start_tx(8'hFF, 13'b1_00000000_0_000, "nack");
    wait_req("nack");
    dev_clock(12, 1'b1, "nack");
    repeat (10) step();
    checki("nack tx_err pulses", n_err - e0, 1);
    checki("nack tx_done pulses", n_done - d0, 0);
    check1("nack clk_oe", ps2_clk_oe, 1'b0);
    check1("nack data_oe", ps2_data_oe, 1'b0);

    d0 = n_done;
    start_tx(8'h55, 13'b1_00000000_0_000, "timeout");
    wait_req("timeout");
    exp_oe_q.delete();
    n = 2;
    #1;
    while (!tx_err && n < TO_CYC + 100) begin @(posedge clk); #2; n++; end
    checki("timeout cycle", n, TO_CYC);
    check1("timeout clk_oe", ps2_clk_oe, 1'b0);
    check1("timeout data_oe", ps2_data_oe, 1'b0);
    check1("timeout no done", tx_done, 1'b0);
    step();
    checki("timeout done count", n_done - d0, 0);

    rx_busy = 1'b1;
    start_tx(8'h00, 13'b1_11111111_0_000, "busy");
    repeat (20) step();
    check1("busy holds off inhibit", ps2_clk_oe, 1'b0);
    rx_pulse(8'h2A, 1'b0, 1'b1, 1'b0, "busy rx");
    #1;
    check1("busy rx queued", key_valid, 1'b1);
    check8("busy rx code", key_code, exp_q[0]);
    rx_busy = 1'b0;
    wait_req("busy");
    dev_clock(4, 1'b0, "busy");
    check1("mid shift data_oe", ps2_data_oe, 1'b1);
    reset = 1'b0;
    #1;
    check1("async rst data_oe", ps2_data_oe, 1'b0);
    check1("async rst clk_oe", ps2_clk_oe, 1'b0);
    check1("async rst fifo", key_valid, 1'b0);
    exp_q.delete();
    exp_oe_q.delete();
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    check1("post rst fifo", key_valid, 1'b0);
    checki("never done and err together", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
